// File: rtl/rt_budget_bench.sv
// Multi-channel request tracker: forwards requests, times out unanswered ones,
// counts responses per channel and raises a registered violation flag.
module rt_budget_bench #(
  parameter int N_CH       = 2,
  parameter int CNT_W      = 3,
  parameter int BUDGET     = 2,
  parameter int TIMEOUT    = 4,
  parameter int STICKY_ERR = 1,
  localparam int TMR_W     = $clog2(TIMEOUT + 1),
  localparam int ECH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   i,
  input  logic [N_CH-1:0]   controllable_i,
  input  logic [N_CH-1:0]   response,
  output logic [N_CH-1:0]   _rt_get,
  output logic [N_CH-1:0]   pending,
  output logic              error,
  output logic [ECH_W-1:0]  err_ch
);

  typedef enum logic {IDLE, PENDING} state_t;

  localparam logic [CNT_W-1:0] BUDGET_V  = CNT_W'(BUDGET);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [TMR_W-1:0] TIMEOUT_V = TMR_W'(TIMEOUT);

  logic [N_CH-1:0] viol;

  assign _rt_get = i;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic               viol_req;
    logic               viol_to;

    // Budget check uses the counter value before this cycle's response lands.
    assign viol_req    = i[gi] & ~((cnt_q <= BUDGET_V) & controllable_i[gi]);
    assign viol[gi]    = viol_req | viol_to;
    assign pending[gi] = (state_q == PENDING);

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmr_d   = tmr_q;
      viol_to = 1'b0;
      case (state_q)
        IDLE: begin
          if (i[gi]) begin
            state_d = PENDING;
            tmr_d   = '0;
          end
        end
        PENDING: begin
          if (response[gi]) begin
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            // A fresh request answered in the same cycle restarts the window.
            if (i[gi]) tmr_d = '0;
            else       state_d = IDLE;
          end else if (tmr_q == TIMEOUT_V) begin
            viol_to = 1'b1;
            state_d = IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        tmr_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        tmr_q   <= tmr_d;
      end
    end
  end

  logic              error_q, error_d;
  logic [ECH_W-1:0]  err_ch_q, err_ch_d;
  logic [ECH_W-1:0]  first_ch;
  logic              any_viol;

  always_comb begin
    first_ch = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (viol[c]) first_ch = ECH_W'(c);
    end
    any_viol = |viol;
    error_d  = (STICKY_ERR != 0) ? (error_q | any_viol) : any_viol;
    err_ch_d = err_ch_q;
    // A sticky error keeps the channel that raised it first.
    if (any_viol && !((STICKY_ERR != 0) && error_q)) err_ch_d = first_ch;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_q  <= 1'b0;
      err_ch_q <= '0;
    end else begin
      error_q  <= error_d;
      err_ch_q <= err_ch_d;
    end
  end

  assign error  = error_q;
  assign err_ch = err_ch_q;

endmodule
